// File: rtl/lm70_multi_spi_reader.sv
// Round-robin SPI master polling NUM_CH LM70-class sensors on a shared SCK/SIO bus.
// Optional hysteresis alarm per channel when LM70_ALARM_EN is defined.
module lm70_multi_spi_reader #(
   parameter int NUM_CH     = 2,
   parameter int FRAME_BITS = 16,
   parameter int TEMP_BITS  = 11,
   parameter int SCK_DIV    = 4,
   parameter int GAP_CYCLES = 8,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        sio,
   output logic                        sck,
   output logic [NUM_CH-1:0]           cs_n,
   output logic [NUM_CH*TEMP_BITS-1:0] temp_flat,
   output logic                        valid,
   output logic [CH_W-1:0]             valid_ch,
   output logic                        busy
`ifdef LM70_ALARM_EN
   ,
   input  logic signed [TEMP_BITS-1:0] thr_hi,
   input  logic signed [TEMP_BITS-1:0] thr_lo,
   output logic [NUM_CH-1:0]           alarm
`endif
);

   localparam int MAX_CNT = (SCK_DIV > GAP_CYCLES) ? SCK_DIV : GAP_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);
   localparam int BIT_W   = $clog2(FRAME_BITS + 1);

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCK_DIV - 1);
   localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
   localparam logic [CH_W-1:0]  PTR_LAST = CH_W'(NUM_CH - 1);

   typedef enum logic [2:0] {
      IDLE,
      CS_SETUP,
      SHIFT,
      CS_HOLD,
      LATCH,
      GAP
   } state_t;

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic [BIT_W-1:0]        bit_cnt;
   logic [CH_W-1:0]         ptr;
   logic [FRAME_BITS-1:0]   shreg;
   logic signed [TEMP_BITS-1:0] new_temp;

   // Temperature field is the leading TEMP_BITS of the frame, MSB first.
   assign new_temp = shreg[FRAME_BITS-1 -: TEMP_BITS];

   function automatic logic [NUM_CH-1:0] cs_sel(input logic [CH_W-1:0] p);
      return ~(NUM_CH'(1) << p);
   endfunction

   // NOTE: every register here is assigned with <= so all next-state values are
   // computed from the same pre-edge snapshot, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_cnt  <= '0;
         ptr      <= '0;
         shreg    <= '0;
         sck      <= 1'b0;
         cs_n     <= '1;
         valid    <= 1'b0;
         valid_ch <= '0;
         busy     <= 1'b0;
         // NOTE: the reading registers are cleared too, so downstream display
         // logic never sees stale data from before a reset.
         temp_flat <= '0;
`ifdef LM70_ALARM_EN
         alarm    <= '0;
`endif
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (en) begin
                  state <= CS_SETUP;
                  cs_n  <= cs_sel(ptr);
                  busy  <= 1'b1;
                  cnt   <= '0;
               end
            end

            CS_SETUP: begin
               if (cnt == DIV_LAST) begin
                  cnt     <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // sio is captured on the same edge that raises sck; the sensor changed
            // it on the previous falling edge, so it has had a full half-period to settle.
            SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt <= '0;
                  if (!sck) begin
                     sck   <= 1'b1;
                     shreg <= (shreg << 1) | FRAME_BITS'(sio);
                  end else begin
                     sck <= 1'b0;
                     if (bit_cnt == BIT_LAST) begin
                        state <= CS_HOLD;
                     end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            CS_HOLD: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  cs_n  <= '1;
                  state <= LATCH;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            LATCH: begin
               for (int k = 0; k < NUM_CH; k++) begin
                  if (ptr == CH_W'(k)) begin
                     temp_flat[k*TEMP_BITS +: TEMP_BITS] <= new_temp;
`ifdef LM70_ALARM_EN
                     if (new_temp > thr_hi) begin
                        alarm[k] <= 1'b1;
                     end else if (new_temp < thr_lo) begin
                        alarm[k] <= 1'b0;
                     end
`endif
                  end
               end
               valid    <= 1'b1;
               valid_ch <= ptr;
               ptr      <= (ptr == PTR_LAST) ? '0 : ptr + CH_W'(1);
               busy     <= 1'b0;
               cnt      <= '0;
               state    <= GAP;
            end

            GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt <= '0;
                  if (en) begin
                     state <= CS_SETUP;
                     cs_n  <= cs_sel(ptr);
                     busy  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               cs_n  <= '1;
               sck   <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lm70_multi_spi_reader.sv
// Self-checking bench for lm70_multi_spi_reader: frame-offset model plus directed scenarios.
// Define LM70_ALARM_EN to also exercise the hysteresis alarm.
module tb_lm70_multi_spi_reader;

   localparam int NUM_CH     = 2;
   localparam int FRAME_BITS = 16;
   localparam int TEMP_BITS  = 11;
   localparam int SCK_DIV    = 4;
   localparam int GAP_CYCLES = 8;
   localparam int CH_W       = 1;

   // Frame timeline measured from the first CS_SETUP cycle.
   localparam int SHIFT_LEN  = 2 * SCK_DIV * FRAME_BITS;
   localparam int CS_CYCLES  = SCK_DIV + SHIFT_LEN + SCK_DIV;
   localparam int LATCH_OFF  = CS_CYCLES;
   localparam int VALID_OFF  = LATCH_OFF + 1;
   localparam int PERIOD     = VALID_OFF + GAP_CYCLES;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b0;
   logic sio;
   logic                        sck;
   logic [NUM_CH-1:0]           cs_n;
   logic [NUM_CH*TEMP_BITS-1:0] temp_flat;
   logic                        valid;
   logic [CH_W-1:0]             valid_ch;
   logic                        busy;
`ifdef LM70_ALARM_EN
   logic signed [TEMP_BITS-1:0] thr_hi = 11'h0A0;
   logic signed [TEMP_BITS-1:0] thr_lo = 11'h08C;
   logic [NUM_CH-1:0]           alarm;
`endif

   lm70_multi_spi_reader #(
      .NUM_CH(NUM_CH), .FRAME_BITS(FRAME_BITS), .TEMP_BITS(TEMP_BITS),
      .SCK_DIV(SCK_DIV), .GAP_CYCLES(GAP_CYCLES)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .sio(sio), .sck(sck), .cs_n(cs_n),
      .temp_flat(temp_flat), .valid(valid), .valid_ch(valid_ch), .busy(busy)
`ifdef LM70_ALARM_EN
      , .thr_hi(thr_hi), .thr_lo(thr_lo), .alarm(alarm)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Sensor: MSB on chip-select fall, next bit after each sck falling edge.
   logic [FRAME_BITS-1:0] frame_word [NUM_CH];
   int   fall_cnt = 0;
   logic sck_s    = 1'b0;

   always @(negedge clk) begin
      if (cs_n === {NUM_CH{1'b1}}) fall_cnt <= 0;
      else if (sck_s && sck === 1'b0) fall_cnt <= fall_cnt + 1;
      sck_s <= (sck === 1'b1);
   end

   always_comb begin
      sio = 1'b0;
      for (int k = 0; k < NUM_CH; k++)
         if (cs_n[k] === 1'b0 && fall_cnt < FRAME_BITS)
            sio = frame_word[k][FRAME_BITS-1-fall_cnt];
   end

   // Bus monitor: frame starts, sck rising edges and chip-select low time per frame.
   int   cyc = 0;
   int   rises = 0;
   int   cs_low_cyc = 0;
   int   starts[$];
   logic all_high_q = 1'b1;
   logic sck_m = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (all_high_q && cs_n !== {NUM_CH{1'b1}}) begin
         starts.push_back(cyc);
         rises      <= 0;
         cs_low_cyc <= 1;
      end else begin
         if (cs_n !== {NUM_CH{1'b1}}) cs_low_cyc <= cs_low_cyc + 1;
         if (!sck_m && sck === 1'b1) rises <= rises + 1;
      end
      all_high_q <= (cs_n === {NUM_CH{1'b1}});
      sck_m      <= (sck === 1'b1);
   end

   // Model: where in the frame timeline we are, which channel, and what got latched.
   bit   m_started = 1'b0;
   bit   m_active  = 1'b0;
   int   m_off = 0;
   int   m_ch  = 0;
   int   m_ptr = 0;
   logic [TEMP_BITS-1:0] m_temp [NUM_CH];
   logic [NUM_CH-1:0]    m_alarm;

   function automatic logic signed [TEMP_BITS-1:0] reading(input logic [FRAME_BITS-1:0] f);
      return TEMP_BITS'(f >> (FRAME_BITS - TEMP_BITS));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_started <= 1'b1;
         m_active  <= 1'b0;
         m_off     <= 0;
         m_ch      <= 0;
         m_ptr     <= 0;
         for (int k = 0; k < NUM_CH; k++) m_temp[k] <= '0;
         m_alarm   <= '0;
      end else if (m_started) begin
         if (!m_active || m_off == PERIOD - 1) begin
            if (en) begin
               m_active <= 1'b1;
               m_off    <= 0;
               m_ch     <= m_ptr;
            end else begin
               m_active <= 1'b0;
            end
         end else begin
            m_off <= m_off + 1;
            if (m_off == LATCH_OFF) begin
               m_temp[m_ch] <= reading(frame_word[m_ch]);
`ifdef LM70_ALARM_EN
               if (reading(frame_word[m_ch]) > thr_hi) m_alarm[m_ch] <= 1'b1;
               else if (reading(frame_word[m_ch]) < thr_lo) m_alarm[m_ch] <= 1'b0;
`endif
               m_ptr <= (m_ptr + 1) % NUM_CH;
            end
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   logic [NUM_CH-1:0]           exp_cs;
   logic                        exp_sck, exp_busy, exp_valid;
   logic [NUM_CH*TEMP_BITS-1:0] exp_flat;

   always @(negedge clk) begin
      if (m_started) begin
         exp_cs    = '1;
         exp_sck   = 1'b0;
         exp_busy  = 1'b0;
         exp_valid = 1'b0;
         if (m_active) begin
            if (m_off < CS_CYCLES) exp_cs[m_ch] = 1'b0;
            exp_sck   = (m_off >= SCK_DIV) && (m_off < SCK_DIV + SHIFT_LEN) &&
                        (((m_off - SCK_DIV) % (2 * SCK_DIV)) >= SCK_DIV);
            exp_busy  = (m_off < VALID_OFF);
            exp_valid = (m_off == VALID_OFF);
         end
         for (int k = 0; k < NUM_CH; k++) exp_flat[k*TEMP_BITS +: TEMP_BITS] = m_temp[k];
         check("cs_n", 64'(cs_n), 64'(exp_cs));
         check("sck", 64'(sck), 64'(exp_sck));
         check("busy", 64'(busy), 64'(exp_busy));
         check("valid", 64'(valid), 64'(exp_valid));
         check("temp_flat", 64'(temp_flat), 64'(exp_flat));
         check("cs_at_most_one_low", 64'($countones(~cs_n) <= 1), 64'(1));
         if (exp_valid) check("valid_ch", 64'(valid_ch), 64'(m_ch));
`ifdef LM70_ALARM_EN
         check("alarm", 64'(alarm), 64'(m_alarm));
`endif
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic wait_valid(input string name, input int limit);
      bit ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick(1);
         if (valid === 1'b1) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: no valid pulse within %0d cycles", name, limit);
      end
   endtask

   task automatic wait_start(input string name, input int limit);
      int  n0 = starts.size();
      bit  ok = 1'b0;
      for (int i = 0; i < limit && !ok; i++) begin
         tick(1);
         if (starts.size() > n0) ok = 1'b1;
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL %s: no frame start within %0d cycles", name, limit);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      frame_word[0] = 16'h0C9F;
      frame_word[1] = 16'hF39F;
      rst = 1'b1;
      en  = 1'b0;
      tick(2);
      check("rst_cs_n", 64'(cs_n), 64'(2'b11));
      check("rst_sck", 64'(sck), 64'(0));
      check("rst_temp", 64'(temp_flat), 64'(0));
      check("rst_valid", 64'(valid), 64'(0));
      check("rst_valid_ch", 64'(valid_ch), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      rst = 1'b0;
      en  = 1'b1;

      // Frame 1: ch0, +25 C
      wait_start("f1_start", 20);
      check("f1_cs", 64'(cs_n), 64'(2'b10));
      wait_valid("f1_valid", 200);
      check("f1_valid_ch", 64'(valid_ch), 64'(0));
      check("f1_temp", 64'(temp_flat[10:0]), 64'(11'h064));
      check("f1_model_temp", 64'(m_temp[0]), 64'(11'h064));
      check("f1_sck_rises", 64'(rises), 64'(16));
      check("f1_cs_low_cycles", 64'(cs_low_cyc), 64'(136));

      // Frame 2: ch1, -25 C
      wait_start("f2_start", 20);
      check("f2_cs", 64'(cs_n), 64'(2'b01));
      check("f2_period", 64'(starts[1] - starts[0]), 64'(145));
      wait_valid("f2_valid", 200);
      check("f2_valid_ch", 64'(valid_ch), 64'(1));
      check("f2_temp", 64'(temp_flat[21:11]), 64'(11'h79C));
      check("f2_model_temp", 64'(m_temp[1]), 64'(11'h79C));

      // Frame 3: pointer wraps back to ch0
      wait_start("f3_start", 20);
      check("f3_cs", 64'(cs_n), 64'(2'b10));
      check("f3_period", 64'(starts[2] - starts[1]), 64'(145));
      wait_valid("f3_valid", 200);
      check("f3_valid_ch", 64'(valid_ch), 64'(0));

      // Frame 4: en dropped mid-SHIFT on ch1; frame still completes, then idle
      wait_start("f4_start", 20);
      check("f4_cs", 64'(cs_n), 64'(2'b01));
      tick(60);
      en = 1'b0;
      wait_valid("f4_valid", 200);
      check("f4_valid_ch", 64'(valid_ch), 64'(1));
      tick(30);
      check("idle_cs", 64'(cs_n), 64'(2'b11));
      check("idle_busy", 64'(busy), 64'(0));
      check("idle_no_start", 64'(starts.size()), 64'(4));
      en = 1'b1;

      // Frame 5: resumes on ch0
      wait_start("f5_start", 20);
      check("f5_cs", 64'(cs_n), 64'(2'b10));
      wait_valid("f5_valid", 200);
      check("f5_valid_ch", 64'(valid_ch), 64'(0));

      // Frame 6: reset at bit 7 of SHIFT aborts it
      wait_start("f6_start", 20);
      for (int i = 0; i < 200 && rises < 7; i++) tick(1);
      check("f6_reached_bit7", 64'(rises), 64'(7));
      rst = 1'b1;
      tick(1);
      check("abort_cs", 64'(cs_n), 64'(2'b11));
      check("abort_sck", 64'(sck), 64'(0));
      check("abort_temp", 64'(temp_flat), 64'(0));
      check("abort_valid", 64'(valid), 64'(0));
      rst = 1'b0;

      // Frame 7: pointer restarted at ch0
      wait_valid("f7_valid", 200);
      check("f7_valid_ch", 64'(valid_ch), 64'(0));
      check("f7_temp", 64'(temp_flat[10:0]), 64'(11'h064));

`ifdef LM70_ALARM_EN
      begin
         logic [FRAME_BITS-1:0] words [3];
         logic                  exp_al [3];
         words[0] = 16'h169F; exp_al[0] = 1'b1;   // 45 C
         words[1] = 16'h12DF; exp_al[1] = 1'b1;   // 37.5 C
         words[2] = 16'h0F1F; exp_al[2] = 1'b0;   // 30 C
         check("alarm0_init", 64'(alarm[0]), 64'(0));
         for (int i = 0; i < 3; i++) begin
            frame_word[0] = words[i];
            wait_valid("alarm_ch1_valid", 200);
            wait_valid("alarm_ch0_valid", 200);
            check("alarm_valid_ch", 64'(valid_ch), 64'(0));
            check("alarm_temp", 64'(temp_flat[10:0]), 64'(reading(words[i])));
            check("alarm0", 64'(alarm[0]), 64'(exp_al[i]));
            check("alarm1", 64'(alarm[1]), 64'(0));
         end
      end
`endif

      tick(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
